horas: RTL

//  Hours stage of the digital clock, directly downstream of the minutes stage.
//  - Consumes the minutes carry (one pulse per 60 minutes) and keeps the hour of day, 0..23.
//  - Supports manual set via the UP/DOWN buttons.
//  - Drives two active-low 7-segment digits, with optional 12h display and PM lamp.
//  - Emits a one-cycle day carry for a later date stage.

---
 rtl/horas.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/horas.sv
// Hours stage of the digital clock: counts minute carries into hour-of-day
// 0..23, supports manual set with UP/DOWN, drives two active-low 7-segment
// digits (24h or 12h with PM lamp) and emits a one-cycle day carry.
module horas #(
    parameter logic [4:0] RESET_HOUR = 5'd0,
    parameter bit         BLANK_ZERO = 1'b1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic carry_in,
    input  logic UP,
    input  logic DOWN,
    input  logic SW16,
    input  logic SW17,
    input  logic SW14,
    output logic dayOUT,
    output logic pm,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic e,
    output logic f,
    output logic g,
    output logic a1,
    output logic b1,
    output logic c1,
    output logic d1,
    output logic e1,
    output logic f1,
    output logic g1
);

    typedef enum logic {
        MODE_SET = 1'b0,
        MODE_RUN = 1'b1
    } mode_t;

    mode_t       mode_q, mode_d;
    logic [4:0]  hour;
    logic [4:0]  hour_d;     // display copy, one cycle behind hour
    logic        carry_q;
    logic        armed;
    logic        rise;

    logic [3:0]  tens, units;
    logic [4:0]  h12;
    logic [6:0]  tens_seg, units_seg;

    // Active-low abcdefg segment pattern for one decimal digit.
    function automatic logic [6:0] seg7(input logic [3:0] digit);
        case (digit)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    assign rise = carry_in & ~carry_q;

    // Mode register: SW17 enables a change, SW16 picks RUN or SET.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) mode_q <= MODE_RUN;
        else          mode_q <= mode_d;
    end

    // Next mode selection.
    always_comb begin
        // NOTE: default first so no path leaves mode_d unassigned (no latch).
        mode_d = mode_q;
        if (SW17) mode_d = SW16 ? MODE_RUN : MODE_SET;
    end

    // Hour counter, carry edge detect, set-mode arming and day carry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hour    <= RESET_HOUR;
            hour_d  <= RESET_HOUR;
            carry_q <= 1'b0;
            armed   <= 1'b0;
            dayOUT  <= 1'b0;
        end else begin
            carry_q <= carry_in;
            hour_d  <= hour;
            dayOUT  <= 1'b0;
            if (mode_q == MODE_RUN) begin
                // Cleared here so a button held on entry to SET cannot step.
                armed <= 1'b0;
                if (rise) begin
                    if (hour >= 5'd23) begin
                        hour   <= 5'd0;
                        dayOUT <= (hour == 5'd23);
                    end else begin
                        hour <= hour + 5'd1;
                    end
                end
            end else begin
                // Re-arm only after a cycle with both buttons released.
                armed <= ~(UP | DOWN);
                if (armed && UP) begin
                    hour <= (hour >= 5'd23) ? 5'd0 : hour + 5'd1;
                end else if (armed && DOWN) begin
                    if (hour == 5'd0)       hour <= 5'd23;
                    else if (hour > 5'd23)  hour <= 5'd0;
                    else                    hour <= hour - 5'd1;
                end
            end
        end
    end

    // Digit split and segment decode from the registered display hour.
    always_comb begin
        tens = 4'd0;
        units = 4'd0;
        h12 = 5'd0;
        pm = 1'b0;
        if (SW14) begin
            h12 = (hour_d >= 5'd12) ? hour_d - 5'd12 : hour_d;
            if (h12 == 5'd0) h12 = 5'd12;
            pm = (hour_d >= 5'd12);
            if (h12 >= 5'd10) begin
                tens  = 4'd1;
                units = 4'(h12 - 5'd10);
            end else begin
                units = 4'(h12);
            end
        end else begin
            if (hour_d >= 5'd20) begin
                tens  = 4'd2;
                units = 4'(hour_d - 5'd20);
            end else if (hour_d >= 5'd10) begin
                tens  = 4'd1;
                units = 4'(hour_d - 5'd10);
            end else begin
                units = 4'(hour_d);
            end
        end
        units_seg = seg7(units);
        tens_seg  = seg7(tens);
        if (SW14 && BLANK_ZERO && tens == 4'd0) tens_seg = 7'b1111111;
    end

    assign {a, b, c, d, e, f, g}         = units_seg;
    assign {a1, b1, c1, d1, e1, f1, g1}  = tens_seg;

endmodule
